// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Accepts a binary value over a valid/ready handshake, converts it to BCD
//   with a sequential double-dabble engine, and time-multiplexes the
//   committed digits onto the shared anodes of a 7-segment display.
//   Codes above 9 are blanked by the downstream decoder: 4'hF is a blank
//   digit and 4'hA marks an overflowed (blanked) display.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   load_valid   load_value is valid this cycle
//   load_value   unsigned binary value to display (BIN_WIDTH bits)
//   load_ready   controller can accept a value (IDLE)
//   busy         conversion / commit in progress
//   overflow     last committed value exceeded 10^NUM_DIGITS-1
//   digit_code   4-bit code of the selected digit, feeds the decoder
//   anode_n      active-low digit enables, at most one bit low
//
// Build option
//   LZ_BLANK_EN  when defined, leading zeros above the most significant
//                nonzero digit are written as 4'hF at commit (digit 0 is
//                always shown).
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [BIN_WIDTH-1:0]  load_value,
  output logic                  load_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] anode_n
);

  localparam int unsigned NIBS   = NUM_DIGITS + 1;
  localparam int          ACC_W  = 4 * NIBS;
  localparam int          DISP_W = 4 * NUM_DIGITS;
  localparam int          CNT_W  = $clog2(REFRESH_DIV);
  localparam int          IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          BC_W   = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                state, state_nx;
  logic [BIN_WIDTH-1:0]  shreg;
  logic [ACC_W-1:0]      acc, acc_adj;
  logic [BC_W-1:0]       bitcnt;
  logic [DISP_W-1:0]     disp, commit_disp, scan_src;
  logic                  commit_ovf;
  logic [CNT_W-1:0]      rcnt;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] anode_nx;
  logic [3:0]            code_nx;

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nx = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (bitcnt == BC_W'(BIN_WIDTH - 1)) state_nx = COMMIT;
      end
      COMMIT: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble: add 3 to every nibble >= 5 before each shift
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Value written to the display register on the COMMIT cycle
  always_comb begin
`ifdef LZ_BLANK_EN
    logic lz;
    lz = 1'b1;
`endif
    commit_ovf  = |acc[ACC_W-1 -: 4];
    commit_disp = acc[DISP_W-1:0];
`ifdef LZ_BLANK_EN
    // Walk down from the top digit; blank zeros until the first nonzero.
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (acc[4*i +: 4] != 4'd0) lz = 1'b0;
      else if (lz)               commit_disp[4*i +: 4] = 4'hF;
    end
`endif
    if (commit_ovf) commit_disp = {NUM_DIGITS{4'hA}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      bitcnt   <= '0;
      disp     <= '1;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg  <= load_value;
            acc    <= '0;
            bitcnt <= '0;
          end
        end
        CONVERT: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          bitcnt       <= bitcnt + BC_W'(1);
        end
        COMMIT: begin
          disp     <= commit_disp;
          overflow <= commit_ovf;
        end
        default: ;
      endcase
    end
  end

  // Scan: on a wrap that coincides with COMMIT, bypass the display register
  // so the new slot already shows the freshly committed digits.
  always_comb begin
    wrap     = (rcnt == CNT_W'(REFRESH_DIV - 1));
    idx_nx   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    scan_src = (state == COMMIT) ? commit_disp : disp;
    code_nx  = scan_src[{idx_nx, 2'b00} +: 4];
    anode_nx = '1;
    anode_nx[idx_nx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt       <= '0;
      idx        <= IDX_W'(NUM_DIGITS - 1);
      anode_n    <= '1;
      digit_code <= 4'hF;
    end else begin
      rcnt <= wrap ? '0 : rcnt + CNT_W'(1);
      if (wrap) begin
        idx        <= idx_nx;
        anode_n    <= anode_nx;
        digit_code <= code_nx;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int ND   = 4;
  localparam int BW   = 14;
  localparam int RD   = 4;
  localparam int CONV = BW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [BW-1:0] load_value = '0;
  logic          load_ready, busy, overflow;
  logic [3:0]    digit_code;
  logic [ND-1:0] anode_n;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_value(load_value),
    .load_ready(load_ready),
    .busy      (busy),
    .overflow  (overflow),
    .digit_code(digit_code),
    .anode_n   (anode_n)
  );

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   edge_n = 0;  // posedges seen
  int   k      = 0;  // posedges since reset released

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Decimal digits of v, least significant first
  function automatic logic [15:0] model_dig(input int v);
    logic [15:0] r;
    int p = 1;
    r = '0;
    if (v > 9999) return 16'hAAAA;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
`ifdef LZ_BLANK_EN
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard on every commit, checks scan outputs
  initial begin
    logic        r, pb, scanning;
    int          idx;
    logic [15:0] ed;
    logic        eo;
    logic [3:0]  ecode, ea;
    exp_t        e;
    pb = 1'b0; idx = ND - 1; scanning = 1'b0; ed = '1; eo = 1'b0; ecode = 4'hF;
    forever begin
      @(posedge clk);
      r = rst;
      edge_n++;
      if (r) k = 0;
      else   k++;
      @(negedge clk);
      if (r) begin
        pb = 1'b0; idx = ND - 1; scanning = 1'b0; ed = '1; eo = 1'b0; ecode = 4'hF;
        chk("rst_load_ready", load_ready, 1);
      end else begin
        if (pb && !busy) begin
          if (sb.size() == 0) chk("spurious_commit", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("commit_latency", edge_n, e.t + CONV);
            ed = e.dig;
            eo = e.ovf;
          end
        end
        if (k % RD == 0) begin
          idx      = (idx + 1) % ND;
          scanning = 1'b1;
          ecode    = ed[4*idx +: 4];
        end
      end
      pb = busy;
      ea = '1;
      if (scanning) ea[idx] = 1'b0;
      chk("anode_n", anode_n, ea);
      chk("digit_code", digit_code, ecode);
      chk("overflow", overflow, eo);
      chk("ready_vs_busy", load_ready, !busy);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) chk("ready_timeout", load_ready, 1);
  endtask

  // align: time the acceptance so the commit lands on a scan wrap edge
  task automatic send(input int v, input bit align);
    exp_t e;
    wait_ready();
    if (align)
      for (int i = 0; i < RD && ((k + 1 + CONV) % RD) != 0; i++) step(1);
    load_valid = 1'b1;
    load_value = BW'(v);
    e.dig = model_dig(v);
    e.ovf = (v > 9999);
    e.t   = edge_n + 1;
    sb.push_back(e);
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(20);                       // blank display scanning

    send(1234, 1'b1); wait_done(); step(18);
    send(42, 1'b0);   wait_done(); step(18);
    send(0, 1'b1);    wait_done(); step(18);
    send(16383, 1'b0); wait_done(); step(18);
    send(9999, 1'b1); wait_done(); step(18);

    // value presented mid-conversion must be ignored
    send(1234, 1'b0);
    step(3);
    load_valid = 1'b1;
    load_value = BW'(5555);
    chk("ignored_ready", load_ready, 0);
    step(1);
    load_valid = 1'b0;
    wait_done(); step(18);

    for (int i = 0; i < 14; i++) begin
      send(int'($urandom_range(0, 16383)), bit'($urandom_range(0, 1)));
      step(int'($urandom_range(0, 20)));
    end
    send(10000, 1'b0);
    send(9, 1'b1);
    wait_done(); step(18);

    // reset in the middle of a conversion
    send(8888, 1'b0);
    step(6);
    rst = 1'b1;
    sb.delete();
    step(1);
    rst = 1'b0;
    step(20);

    send(7, 1'b0);
    wait_done();
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
